// File: rtl/bsg_concentrate_pkg.sv
// bsg_concentrate_pkg
//   Shared definitions for the dynamic bit concentrator.
//   - out_state_e : occupancy of the single-entry output register.
//   - count_width : bits needed to hold a popcount of a width-bit mask.
package bsg_concentrate_pkg;

   typedef enum logic [0:0] {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_e;

   function automatic int count_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/bsg_concentrate_dynamic_core.sv
// bsg_concentrate_dynamic_core
//   Purely combinational compaction datapath. Every input bit gets the
//   number of set mask bits below it (prefix popcount); that number is the
//   output slot the bit lands in. Each output bit is then a one-hot OR-mux
//   over the input bits whose slot equals its index.
// Ports:
//   mask_i  [width_p]       selection mask, bit k=1 selects data_i[k]
//   data_i  [width_p]       word to compact
//   data_o  [out_width_p]   compacted word, unused upper bits are 0
//   count_o [clog2(w+1)]    popcount of mask_i
module bsg_concentrate_dynamic_core
   import bsg_concentrate_pkg::*;
#(
   parameter int width_p     = 32,
   parameter int out_width_p = 16
)
(
   input  logic [width_p-1:0]           mask_i,
   input  logic [width_p-1:0]           data_i,
   output logic [out_width_p-1:0]       data_o,
   output logic [$clog2(width_p+1)-1:0] count_o
);

   localparam int count_w_lp = count_width(width_p);

   // prefix_s[i] = number of set mask bits strictly below index i
   logic [count_w_lp-1:0] prefix_s [width_p+1];

   // Running prefix popcount over the mask.
   always_comb begin
      prefix_s[0] = {count_w_lp{1'b0}};
      for (int i = 0; i < width_p; i++) begin
         prefix_s[i+1] = prefix_s[i] + count_w_lp'(mask_i[i]);
      end
   end

   // One-hot mux per output bit; selected bits whose slot is at or beyond
   // out_width_p match no output index and are therefore dropped.
   always_comb begin
      data_o = {out_width_p{1'b0}};
      for (int j = 0; j < out_width_p; j++) begin
         for (int i = 0; i < width_p; i++) begin
            data_o[j] = data_o[j]
                      | (mask_i[i] & data_i[i] & (prefix_s[i] == count_w_lp'(j)));
         end
      end
   end

   assign count_o = prefix_s[width_p];

endmodule

// File: rtl/bsg_concentrate_dynamic.sv
// bsg_concentrate_dynamic
//   Runtime-programmable bit concentrator with a registered, flow-controlled
//   output. Holds the mask register, a single-entry output register and the
//   valid/ready (in) and valid/yumi (out) handshake.
// Ports:
//   clk_i, reset_i       clock, synchronous active-high reset
//   cfg_v_i, cfg_mask_i  mask write strobe and new mask (always accepted)
//   v_i, data_i, ready_o input handshake; accepted when v_i & ready_o
//   v_o, data_o, yumi_i  output handshake; consumer takes word on yumi_i
//   count_o              popcount of the current mask
//   overflow_o           current mask selects more bits than out_width_p
module bsg_concentrate_dynamic
   import bsg_concentrate_pkg::*;
#(
   parameter int                 width_p      = 32,
   parameter int                 out_width_p  = 16,
   parameter logic [width_p-1:0] reset_mask_p = width_p'(32'h0000_EDBF)
)
(
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         cfg_v_i,
   input  logic [width_p-1:0]           cfg_mask_i,
   input  logic                         v_i,
   input  logic [width_p-1:0]           data_i,
   output logic                         ready_o,
   output logic                         v_o,
   output logic [out_width_p-1:0]       data_o,
   input  logic                         yumi_i,
   output logic [$clog2(width_p+1)-1:0] count_o,
   output logic                         overflow_o
);

   localparam int                    count_w_lp   = count_width(width_p);
   localparam logic [count_w_lp-1:0] out_width_lp = count_w_lp'(out_width_p);

   logic [width_p-1:0]     mask_r;
   out_state_e             state_r;
   out_state_e             state_s;
   logic [out_width_p-1:0] data_r;
   logic [out_width_p-1:0] core_data_s;
   logic [count_w_lp-1:0]  core_count_s;
   logic                   accept_s;
   logic                   yumi_s;
   logic                   ready_s;

   bsg_concentrate_dynamic_core #(
      .width_p     (width_p),
      .out_width_p (out_width_p)
   ) core (
      .mask_i  (mask_r),
      .data_i  (data_i),
      .data_o  (core_data_s),
      .count_o (core_count_s)
   );

   // A yumi with nothing to take is ignored rather than corrupting state.
   assign yumi_s   = yumi_i & (state_r == OUT_FULL);
   assign ready_s  = ~reset_i & ((state_r == OUT_EMPTY) | yumi_s);
   assign accept_s = v_i & ready_s;

   // Output register occupancy: load on accept, drain on yumi, else hold.
   always_comb begin
      state_s = state_r;
      case (state_r)
         OUT_EMPTY: begin
            if (accept_s) begin
               state_s = OUT_FULL;
            end else begin
               state_s = OUT_EMPTY;
            end
         end
         OUT_FULL: begin
            if (accept_s) begin
               state_s = OUT_FULL;
            end else if (yumi_s) begin
               state_s = OUT_EMPTY;
            end else begin
               state_s = OUT_FULL;
            end
         end
         default: begin
            state_s = OUT_EMPTY;
         end
      endcase
   end

   // Mask, occupancy and output data registers. The core sees mask_r, so a
   // word accepted alongside a mask write is compacted with the old mask.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         mask_r  <= reset_mask_p;
         state_r <= OUT_EMPTY;
         data_r  <= {out_width_p{1'b0}};
      end else begin
         if (cfg_v_i) begin
            mask_r <= cfg_mask_i;
         end
         state_r <= state_s;
         if (accept_s) begin
            data_r <= core_data_s;
         end
      end
   end

   assign ready_o    = ready_s;
   assign v_o        = (state_r == OUT_FULL);
   assign data_o     = data_r;
   assign count_o    = core_count_s;
   assign overflow_o = (core_count_s > out_width_lp);

endmodule

// File: tb/tb_bsg_concentrate_dynamic.sv
// tb_bsg_concentrate_dynamic
//   Directed self-checking bench for bsg_concentrate_dynamic (32 -> 16,
//   reset mask 32'h0000_EDBF: bits 0-5,7,8,10,11,13,14,15, popcount 13).
module tb_bsg_concentrate_dynamic;

   localparam int W  = 32;
   localparam int OW = 16;
   localparam int CW = $clog2(W+1);

   logic          clk = 1'b0;
   logic          reset_i;
   logic          cfg_v_i;
   logic [W-1:0]  cfg_mask_i;
   logic          v_i;
   logic [W-1:0]  data_i;
   logic          ready_o;
   logic          v_o;
   logic [OW-1:0] data_o;
   logic          yumi_i;
   logic [CW-1:0] count_o;
   logic          overflow_o;

   int checks = 0;
   int errors = 0;

   logic [W-1:0]  sb_mask;
   logic [OW-1:0] sb_q [$];

   always #5 clk = ~clk;

   bsg_concentrate_dynamic #(
      .width_p      (W),
      .out_width_p  (OW),
      .reset_mask_p (32'h0000_EDBF)
   ) dut (
      .clk_i      (clk),
      .reset_i    (reset_i),
      .cfg_v_i    (cfg_v_i),
      .cfg_mask_i (cfg_mask_i),
      .v_i        (v_i),
      .data_i     (data_i),
      .ready_o    (ready_o),
      .v_o        (v_o),
      .data_o     (data_o),
      .yumi_i     (yumi_i),
      .count_o    (count_o),
      .overflow_o (overflow_o)
   );

   // Reference compaction: walk the mask LSB first, fill output slots in order.
   function automatic logic [OW-1:0] ref_compact(input logic [W-1:0] m, input logic [W-1:0] d);
      logic [OW-1:0] r;
      int j;
      r = '0;
      j = 0;
      for (int i = 0; i < W; i++) begin
         if (m[i]) begin
            if (j < OW) r[j] = d[i];
            j++;
         end
      end
      return r;
   endfunction

   // yumi_i is only legal while v_o is high.
   always @(negedge clk) begin
      if (!reset_i && yumi_i) begin
         checks++;
         if (v_o !== 1'b1) begin
            errors++;
            $display("FAIL yumi_legal: yumi_i=1 while v_o=%b (required 1)", v_o);
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_i = 1'b1; cfg_v_i = 1'b0; cfg_mask_i = '0;
      v_i = 1'b1; data_i = 32'hFFFF_FFFF; yumi_i = 1'b0;
      #1;
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", ready_o); end
      cycle();
      cycle();
      reset_i = 1'b0; v_i = 1'b0;
      #1;
      checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v: got %b required 0", v_o); end
      checks++; if (data_o !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h required 0000", data_o); end
      checks++; if (count_o !== 6'd13) begin errors++; $display("FAIL reset_count: got %0d required 13", count_o); end
      checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b required 0", overflow_o); end
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b required 1", ready_o); end
   endtask

   task automatic test_compaction();
      v_i = 1'b1; data_i = 32'h0000_A5A5; yumi_i = 1'b0;
      cycle();
      checks++; if (v_o !== 1'b1) begin errors++; $display("FAIL comp_a5a5_v: got %b required 1", v_o); end
      checks++; if (data_o !== 16'h15E5) begin errors++; $display("FAIL comp_a5a5: got %h required 15e5", data_o); end
      data_i = 32'h0000_FFFF; yumi_i = 1'b1;
      #1;
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL comp_ready_yumi: got %b required 1", ready_o); end
      cycle();
      checks++; if (data_o !== 16'h1FFF) begin errors++; $display("FAIL comp_ffff: got %h required 1fff", data_o); end
      data_i = 32'hFFFF_0000;
      cycle();
      checks++; if (data_o !== 16'h0000) begin errors++; $display("FAIL comp_hi: got %h required 0000", data_o); end
      checks++; if (v_o !== 1'b1) begin errors++; $display("FAIL comp_hi_v: got %b required 1", v_o); end
      v_i = 1'b0;
      cycle();
      yumi_i = 1'b0;
      checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL comp_drain_v: got %b required 0", v_o); end
   endtask

   task automatic test_overflow_bounds();
      cfg_v_i = 1'b1; cfg_mask_i = 32'h0000_FFFF;
      cycle();
      checks++; if (count_o !== 6'd16) begin errors++; $display("FAIL ovf16_count: got %0d required 16", count_o); end
      checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf16_flag: got %b required 0", overflow_o); end
      cfg_mask_i = 32'h0001_FFFF;
      cycle();
      checks++; if (count_o !== 6'd17) begin errors++; $display("FAIL ovf17_count: got %0d required 17", count_o); end
      checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf17_flag: got %b required 1", overflow_o); end
      cfg_mask_i = 32'hFFFF_FFFF;
      cycle();
      cfg_v_i = 1'b0;
      checks++; if (count_o !== 6'd32) begin errors++; $display("FAIL ovf32_count: got %0d required 32", count_o); end
      checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf32_flag: got %b required 1", overflow_o); end
      v_i = 1'b1; data_i = 32'h1234_ABCD;
      cycle();
      v_i = 1'b0;
      checks++; if (data_o !== 16'hABCD) begin errors++; $display("FAIL ovf_data: got %h required abcd", data_o); end
   endtask

   task automatic test_backpressure();
      v_i = 1'b1; data_i = 32'h5555_2222; yumi_i = 1'b0;
      #1;
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b required 0", ready_o); end
      for (int k = 0; k < 5; k++) begin
         cycle();
         checks++; if (v_o !== 1'b1 || data_o !== 16'hABCD) begin
            errors++; $display("FAIL bp_hold[%0d]: got v=%b data=%h required v=1 data=abcd", k, v_o, data_o);
         end
      end
      yumi_i = 1'b1;
      #1;
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_yumi: got %b required 1", ready_o); end
      cycle();
      v_i = 1'b0; yumi_i = 1'b0;
      checks++; if (v_o !== 1'b1 || data_o !== 16'h2222) begin
         errors++; $display("FAIL bp_replace: got v=%b data=%h required v=1 data=2222", v_o, data_o);
      end
      yumi_i = 1'b1;
      cycle();
      yumi_i = 1'b0;
      checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b required 0", v_o); end
   endtask

   task automatic test_back_to_back();
      logic [OW-1:0] exp_d;
      logic          exp_ready;
      sb_mask = $urandom;
      cfg_v_i = 1'b1; cfg_mask_i = sb_mask;
      cycle();
      cfg_v_i = 1'b0;
      sb_q.delete();
      for (int n = 0; n < 1000; n++) begin
         v_i    = 1'($urandom_range(0, 1));
         data_i = $urandom;
         yumi_i = (sb_q.size() != 0) && ($urandom_range(0, 1) == 1);
         #1;
         exp_ready = (sb_q.size() == 0) || yumi_i;
         checks++; if (ready_o !== exp_ready) begin errors++; $display("FAIL sb_ready[%0d]: got %b required %b", n, ready_o, exp_ready); end
         checks++; if (v_o !== (sb_q.size() != 0)) begin errors++; $display("FAIL sb_v[%0d]: got %b required %b", n, v_o, sb_q.size() != 0); end
         if (yumi_i) begin
            exp_d = sb_q.pop_front();
            checks++; if (data_o !== exp_d) begin errors++; $display("FAIL sb_data[%0d]: got %h required %h", n, data_o, exp_d); end
         end
         if (v_i && exp_ready) sb_q.push_back(ref_compact(sb_mask, data_i));
         @(posedge clk);
         #1;
      end
      v_i = 1'b0; yumi_i = 1'b0;
      if (sb_q.size() != 0) begin
         exp_d = sb_q.pop_front();
         checks++; if (data_o !== exp_d) begin errors++; $display("FAIL sb_last: got %h required %h", data_o, exp_d); end
         yumi_i = 1'b1;
         cycle();
         yumi_i = 1'b0;
      end
      checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL sb_empty: got %b required 0", v_o); end
   endtask

   task automatic test_reset_pending();
      v_i = 1'b1; data_i = 32'h0000_00FF;
      cycle();
      v_i = 1'b0;
      checks++; if (v_o !== 1'b1) begin errors++; $display("FAIL rp_pending: got %b required 1", v_o); end
      reset_i = 1'b1; cfg_v_i = 1'b1; cfg_mask_i = 32'h0F0F_0F0F; v_i = 1'b1; data_i = 32'hFFFF_FFFF;
      #1;
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL rp_ready: got %b required 0", ready_o); end
      cycle();
      reset_i = 1'b0; cfg_v_i = 1'b0; v_i = 1'b0;
      checks++; if (v_o !== 1'b0 || data_o !== 16'h0000) begin
         errors++; $display("FAIL rp_cleared: got v=%b data=%h required v=0 data=0000", v_o, data_o);
      end
      checks++; if (count_o !== 6'd13) begin errors++; $display("FAIL rp_count: got %0d required 13", count_o); end
      v_i = 1'b1; data_i = 32'h0000_A5A5;
      cycle();
      v_i = 1'b0;
      checks++; if (data_o !== 16'h15E5) begin errors++; $display("FAIL rp_first: got %h required 15e5", data_o); end
      yumi_i = 1'b1;
      cycle();
      yumi_i = 1'b0;
   endtask

   task automatic test_cfg_race();
      // 0xF0 under the reset mask: bits 4,5,7 selected -> slots 4,5,6.
      cfg_v_i = 1'b1; cfg_mask_i = 32'h0000_000F; v_i = 1'b1; data_i = 32'h0000_00F0;
      cycle();
      cfg_v_i = 1'b0;
      checks++; if (data_o !== 16'h0070) begin errors++; $display("FAIL race_old_mask: got %h required 0070", data_o); end
      checks++; if (count_o !== 6'd4) begin errors++; $display("FAIL race_count: got %0d required 4", count_o); end
      data_i = 32'h0000_00F5; yumi_i = 1'b1;
      cycle();
      v_i = 1'b0; yumi_i = 1'b0;
      checks++; if (data_o !== 16'h0005) begin errors++; $display("FAIL race_new_mask: got %h required 0005", data_o); end
   endtask

   task automatic test_zero_mask();
      cfg_v_i = 1'b1; cfg_mask_i = 32'h0000_0000; yumi_i = 1'b1;
      cycle();
      cfg_v_i = 1'b0; yumi_i = 1'b0;
      checks++; if (count_o !== 6'd0 || overflow_o !== 1'b0) begin
         errors++; $display("FAIL zero_count: got count=%0d ovf=%b required 0 0", count_o, overflow_o);
      end
      v_i = 1'b1; data_i = 32'hFFFF_FFFF;
      cycle();
      v_i = 1'b0;
      checks++; if (v_o !== 1'b1 || data_o !== 16'h0000) begin
         errors++; $display("FAIL zero_data: got v=%b data=%h required v=1 data=0000", v_o, data_o);
      end
      yumi_i = 1'b1;
      cycle();
      yumi_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_compaction();
      test_overflow_bounds();
      test_backpressure();
      test_back_to_back();
      test_reset_pending();
      test_cfg_race();
      test_zero_mask();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
